// File: rtl/seq_add_sub_if.sv
// Handshake and result bundle for the chunk-serial adder/subtractor.
// The master modport is the ALU sequencer side; the slave modport is the adder.
interface seq_add_sub_if #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
);
    localparam int NCHUNK = WIDTH / CHUNK;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic              carry;
    logic [NCHUNK-1:0] chunk_carry;
    logic              overflow;
    logic              busy;

    modport master (
        output in_valid, in_a, in_b, sub, out_ready,
        input  in_ready, out_valid, result, carry, chunk_carry, overflow, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, sub, out_ready,
        output in_ready, out_valid, result, carry, chunk_carry, overflow, busy
    );
endinterface

// File: rtl/seq_add_sub.sv
// Chunk-serial adder/subtractor: CHUNK bits per clock, LS chunk first, ripple carry in a register.
// Define SEQ_ADD_SAT_EN to saturate the result on signed overflow.
module seq_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic          clk,
    input logic          rst,
    seq_add_sub_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  result_reg;
    logic [WIDTH-1:0]  result_next;
    logic [NCHUNK-1:0] chunk_carry_reg;
    logic              carry_reg;
    logic              overflow_reg;
    logic [IDX_W-1:0]  idx;

    logic [CHUNK:0]    sum;
    logic              last_chunk;
    logic              overflow_next;
    logic              in_ready;
    logic              out_valid;
    logic              busy;

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands shift right one chunk per cycle, so the active chunk is always at bit 0
    // and on the last chunk bit CHUNK-1 holds the operand sign bits.
    always_comb begin
        sum           = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, carry_reg};
        last_chunk    = (idx == LAST_IDX);
        overflow_next = (a_reg[CHUNK-1] == b_reg[CHUNK-1])
                     && (sum[CHUNK-1] != a_reg[CHUNK-1]);
        result_next   = result_reg;
        result_next[32'(idx) * CHUNK +: CHUNK] = sum[CHUNK-1:0];
`ifdef SEQ_ADD_SAT_EN
        if (last_chunk && overflow_next) begin
            result_next = a_reg[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg           <= '0;
            b_reg           <= '0;
            result_reg      <= '0;
            chunk_carry_reg <= '0;
            carry_reg       <= 1'b0;
            overflow_reg    <= 1'b0;
            idx             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
                        a_reg           <= bus.in_a;
                        b_reg           <= bus.sub ? ~bus.in_b : bus.in_b;
                        carry_reg       <= bus.sub;
                        result_reg      <= '0;
                        chunk_carry_reg <= '0;
                        overflow_reg    <= 1'b0;
                        idx             <= '0;
                    end
                end
                RUN: begin
                    a_reg                <= a_reg >> CHUNK;
                    b_reg                <= b_reg >> CHUNK;
                    result_reg           <= result_next;
                    chunk_carry_reg[idx] <= sum[CHUNK];
                    carry_reg            <= sum[CHUNK];
                    idx                  <= idx + 1'b1;
                    if (last_chunk) begin
                        overflow_reg <= overflow_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.busy        = busy;
    assign bus.result      = result_reg;
    assign bus.carry       = carry_reg;
    assign bus.chunk_carry = chunk_carry_reg;
    assign bus.overflow    = overflow_reg;
endmodule
